// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: sequential PC, one-deep in-flight tracking, and a
// small prefetch queue feeding decode through a valid/ready head interface.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        SysCLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [3:0]  q_count
);

    // Handshake: the head entry is consumed on a rising edge where
    // if_valid=1 and dec_ready=1 (unless a redirect flushes it that cycle);
    // if_* hold stable while if_valid=1 and dec_ready=0.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_req_live;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_ipc   [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [3:0]    r_count;

    logic          w_deq;
    logic          w_enq;
    logic          w_req;
    logic [4:0]    w_occupancy;
    logic [31:0]   w_addr;

    // A dequeue this cycle frees a slot in time for a request issued now,
    // which keeps a full queue streaming at one instruction per cycle.
    always_comb begin
        w_addr      = {r_pc[31:2], 2'b00};
        w_deq       = if_valid & dec_ready & ~redirect_valid;
        w_enq       = r_req_live & ~redirect_valid;
        w_occupancy = {1'b0, r_count} + {4'b0000, r_req_live} - {4'b0000, w_deq};
        w_req       = RST & ~redirect_valid & (w_occupancy < 5'(DEPTH));
    end

    always_ff @(posedge SysCLK) begin
        if (!RST) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= 32'h0;
            r_req_live <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 4'd0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_req_live <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 4'd0;
        end else begin
            r_req_live <= w_req;
            if (w_req) begin
                r_req_pc <= w_addr;
                r_pc     <= w_addr + 32'd4;
            end
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: empty slots are masked at the head outputs.
    always_ff @(posedge SysCLK) begin
        if (RST && w_enq) begin
            r_instr[r_tail] <= imem_rdata;
            r_ipc[r_tail]   <= r_req_pc;
        end
    end

    always_comb begin
        imem_req    = w_req;
        imem_addr   = w_addr;
        if_valid    = (r_count != 4'd0);
        if_instr    = if_valid ? r_instr[r_head] : 32'h0;
        if_pc       = if_valid ? r_ipc[r_head] : 32'h0;
        if_pc_plus4 = if_pc + 32'd4;
        q_count     = r_count;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: registered memory model, PC-stream scoreboard
// and directed checks for latency, back-pressure, redirect and reset.
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

    logic        SysCLK;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [3:0]  q_count;

    int          n_tests;
    int          n_fail;
    int          n_req;
    logic        found;
    logic [63:0] exp_q[$];
    logic [63:0] sb_entry;
    logic [31:0] exp_pc;

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .SysCLK(SysCLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .q_count(q_count)
    );

    // clock / reset block
    initial SysCLK = 1'b0;
    always #5 SysCLK = ~SysCLK;

    // Memory answers one cycle after a request with a recognisable word.
    always @(posedge SysCLK) begin
        imem_rdata <= imem_req ? (imem_addr ^ MEM_KEY) : 32'h0BAD_0BAD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge SysCLK);
        #1;
    endtask

    // Scoreboard: expected entries pushed as requests issue, popped on consume.
    always @(negedge SysCLK) begin
        if (!RST) begin
            exp_q.delete();
            exp_pc = RESET_PC;
        end else if (redirect_valid) begin
            check("req_in_redirect", 32'(imem_req), 32'd0);
            exp_q.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (if_valid && dec_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    sb_entry = exp_q.pop_front();
                    check("sb_pc", if_pc, sb_entry[63:32]);
                    check("sb_instr", if_instr, sb_entry[31:0]);
                    check("sb_pc_plus4", if_pc_plus4, sb_entry[63:32] + 32'd4);
                end
            end
            if (imem_req) begin
                check("req_addr", imem_addr, exp_pc);
                exp_q.push_back({exp_pc, exp_pc ^ MEM_KEY});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; n_req = 0; found = 1'b0;
        RST = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // reset values
        repeat (2) next_cycle();
        @(negedge SysCLK);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'd4);
        check("rst_count", 32'(q_count), 32'd0);

        // first fetches and two-cycle latency
        next_cycle(); RST = 1'b1; dec_ready = 1'b1;
        @(negedge SysCLK);
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(if_valid), 32'd0);
        next_cycle(); @(negedge SysCLK);
        check("c1_addr", imem_addr, 32'h4);
        check("c1_valid", 32'(if_valid), 32'd0);
        next_cycle(); @(negedge SysCLK);
        check("c2_addr", imem_addr, 32'h8);
        check("c2_valid", 32'(if_valid), 32'd1);
        check("c2_pc", if_pc, 32'h0);
        check("c2_instr", if_instr, 32'hA5A5_0000);
        for (int i = 0; i < 8; i++) begin
            next_cycle(); @(negedge SysCLK);
            check("stream_req", 32'(imem_req), 32'd1);
            check("stream_valid", 32'(if_valid), 32'd1);
        end

        // back-pressure fills the queue, then drains in order
        next_cycle(); RST = 1'b0; dec_ready = 1'b0;
        next_cycle(); RST = 1'b1;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge SysCLK);
            if (imem_req) n_req++;
            next_cycle();
        end
        check("full_req_count", 32'(n_req), 32'd4);
        @(negedge SysCLK);
        check("full_count", 32'(q_count), 32'(DEPTH));
        check("full_req", 32'(imem_req), 32'd0);
        next_cycle(); dec_ready = 1'b1;
        @(negedge SysCLK);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h10);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); @(negedge SysCLK);
            check("full_stream_req", 32'(imem_req), 32'd1);
            check("full_stream_count", 32'(q_count), 32'(DEPTH - 1));
        end

        // redirect with three queued entries and one in flight
        next_cycle(); RST = 1'b0; dec_ready = 1'b0;
        next_cycle(); RST = 1'b1;
        repeat (4) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; dec_ready = 1'b1;
        @(negedge SysCLK);
        check("pre_redir_count", 32'(q_count), 32'd3);
        next_cycle(); redirect_valid = 1'b0;
        @(negedge SysCLK);
        check("redir_count", 32'(q_count), 32'd0);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_valid", 32'(if_valid), 32'd0);
        next_cycle(); @(negedge SysCLK);
        check("redir_no_stale", 32'(if_valid), 32'd0);
        next_cycle(); @(negedge SysCLK);
        check("redir_head_valid", 32'(if_valid), 32'd1);
        check("redir_head_pc", if_pc, 32'h0000_0100);

        // back-to-back redirects and address wrap
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        next_cycle(); redirect_pc = 32'hFFFF_FFF8;
        @(negedge SysCLK);
        check("b2b_req", 32'(imem_req), 32'd0);
        next_cycle(); redirect_valid = 1'b0;
        @(negedge SysCLK);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        next_cycle(); @(negedge SysCLK);
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        next_cycle(); @(negedge SysCLK);
        check("wrap_addr2", imem_addr, 32'h0000_0000);
        check("wrap_head0", if_pc, 32'hFFFF_FFF8);
        next_cycle(); @(negedge SysCLK);
        check("wrap_head1", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_pc_plus4, 32'h0000_0000);
        repeat (3) next_cycle();

        // reset mid-operation with three queued entries
        dec_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            next_cycle();
            if (q_count == 4'd3) found = 1'b1;
        end
        check("mid_rst_setup", 32'(found), 32'd1);
        RST = 1'b0;
        next_cycle(); RST = 1'b1; dec_ready = 1'b1;
        @(negedge SysCLK);
        check("mid_rst_count", 32'(q_count), 32'd0);
        check("mid_rst_valid", 32'(if_valid), 32'd0);
        check("mid_rst_req", 32'(imem_req), 32'd1);
        check("mid_rst_addr", imem_addr, RESET_PC);
        repeat (8) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the prefetch queue entry count (power of two, 2..8).
REQ-003 SHALL have port SysCLK  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  meaning the reset, synchronous and active-low.
REQ-005 SHALL have port imem_req  output  1  meaning fetch request to instruction memory this cycle.
REQ-006 SHALL have port imem_addr  output  32  meaning byte address of the request, always word-aligned.
REQ-007 SHALL have port imem_rdata  input  32  meaning instruction word, valid exactly one cycle after its request.
REQ-008 SHALL have port redirect_valid  input  1  meaning branch/jump redirect from the execute stage.
REQ-009 SHALL have port redirect_pc  input  32  meaning the redirect target address.
REQ-010 SHALL have port dec_ready  input  1  meaning the decode stage accepts the head entry.
REQ-011 SHALL have port if_valid  output  1  meaning the head entry is valid.
REQ-012 SHALL have port if_instr  output  32  meaning the head instruction word.
REQ-013 SHALL have port if_pc  output  32  meaning the head instruction address.
REQ-014 SHALL have port if_pc_plus4  output  32  meaning if_pc + 4, modulo 2^32.
REQ-015 SHALL have port q_count  output  4  meaning the number of valid queue entries.

Function
REQ-016 SHALL hold a fetch PC register; imem_addr SHALL equal it with bits [1:0] forced to 0.
REQ-017 SHALL assert imem_req when (q_count + in-flight count) < DEPTH and redirect_valid is 0; on each request, PC advances by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 SHALL track at most one in-flight request (req_pc, req_live) and write imem_rdata with req_pc into the queue tail on the cycle after the request.
REQ-019 Latency: request in cycle N -> data on imem_rdata in N+1 -> if_valid/if_instr at head in N+2 when the queue was empty; no combinational bypass.
REQ-020 Head SHALL dequeue on a rising edge where if_valid and dec_ready are both 1; if_* SHALL hold stable while if_valid=1 and dec_ready=0.
REQ-021 Simultaneous enqueue and dequeue SHALL be legal at any occupancy, including full, leaving q_count unchanged.
REQ-022 Credit accounting SHALL guarantee no enqueue ever occurs with q_count = DEPTH; queue pointers wrap modulo DEPTH.
REQ-023 Redirect (redirect_valid=1) SHALL take priority: in that cycle imem_req=0, the queue flushes (q_count->0), any in-flight response is discarded, and PC loads {redirect_pc[31:2],2'b00}.
REQ-024 A dequeue handshake coinciding with redirect SHALL be ignored (entry flushed, not counted as consumed).
REQ-025 The first request after redirect SHALL issue the cycle after redirect_valid, at the redirect target.
REQ-026 Back-to-back redirects SHALL each reload PC; only the last one's target is fetched.
REQ-027 In steady state with dec_ready=1 and no redirect, SHALL sustain one instruction per cycle.

Reset
REQ-028 While RST=0 at a rising edge: PC<=RESET_PC, queue empty, in-flight cleared.
REQ-029 Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4, q_count=0.
REQ-030 Reset asserted mid-operation SHALL discard queued and in-flight data with no enqueue on the reset edge; the first request SHALL issue in the first cycle with RST=1.

Verification
REQ-031 Release reset, dec_ready=1, memory returns addr^32'hA5A5_0000 -> requests at 0x0,0x4,0x8 on consecutive cycles; if_valid first high 2 cycles after first request with if_pc=0, if_instr=32'hA5A5_0000.
REQ-032 dec_ready=0 for 10 cycles -> q_count saturates at 4, imem_req drops, exactly 4 requests issued; raise dec_ready -> entries 0x0..0xC in order, then fetching resumes at 0x10.
REQ-033 Queue full, dec_ready=1 -> imem_req stays 1 and q_count stays constant.
REQ-034 Redirect to 0x0000_0103 with 3 queued entries and one in flight -> next cycle q_count=0, imem_addr=0x0000_0100; stale response never appears; first if_pc=0x100.
REQ-035 redirect_pc=0xFFFF_FFF8 -> fetched PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; if_pc_plus4 of 0xFFFF_FFFC equals 0.
REQ-036 RST=0 for one cycle while q_count=3 -> q_count=0, if_valid=0 next cycle; refetch starts at RESET_PC.
